// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory port arbiter
package dmem_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RD    = 3'd1,
      ST_MERGE = 3'd2,
      ST_WR    = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   typedef enum logic {
      REQ_CPU = 1'b0,
      REQ_DBG = 1'b1
   } req_id_e;

   localparam logic [1:0] SZ_NONE = 2'b00;
   localparam logic [1:0] SZ_B    = 2'b01;
   localparam logic [1:0] SZ_H    = 2'b10;
   localparam logic [1:0] SZ_W    = 2'b11;

   localparam logic [31:0] DMEM_BASE_ADDR = 32'h0000_0800;
   // Offset of the last word inside the CPU window (128 words).
   localparam logic [31:0] DMEM_WIN_LAST  = 32'h0000_01FC;

endpackage

// File: rtl/dmem_lane_merge.sv
// rtl/dmem_lane_merge.sv - merges right-aligned store data into the addressed byte lanes
module dmem_lane_merge
   import dmem_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] old_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [1:0]        size_i,
   input  logic [1:0]        addr_i,
   output logic [DATA_W-1:0] merged_o
);

   always_comb begin
      merged_o = old_i;
      case (size_i)
         SZ_B: begin
            case (addr_i)
               2'd0: merged_o[7:0]   = wdata_i[7:0];
               2'd1: merged_o[15:8]  = wdata_i[7:0];
               2'd2: merged_o[23:16] = wdata_i[7:0];
               default: merged_o[31:24] = wdata_i[7:0];
            endcase
         end
         // Halfword lane comes from addr bit 1 only; a misaligned bit 0 is ignored.
         SZ_H: begin
            if (addr_i[1]) merged_o[31:16] = wdata_i[15:0];
            else           merged_o[15:0]  = wdata_i[15:0];
         end
         SZ_W:    merged_o = wdata_i;
         default: merged_o = old_i;
      endcase
   end

endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares the data RAM between CPU and debug ports with RMW sub-word stores
module dmem_port_arbiter
   import dmem_pkg::*;
#(
   parameter int          ADDR_W    = 7,
   parameter int          DATA_W    = 32,
   parameter logic [31:0] BASE_ADDR = DMEM_BASE_ADDR
) (
   input  logic              CLK,
   input  logic              RESETn,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [1:0]        c_size,
   input  logic [31:0]       c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   output logic [DATA_W-1:0] c_rdata,
   output logic              c_ready,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              m_en,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata
);

   state_e            state_q, state_d;
   req_id_e           last_gnt_q, last_gnt_d;
   req_id_e           gnt_q, gnt_d;
   logic              store_q, store_d;
   logic [1:0]        size_q, size_d;
   logic [1:0]        lane_q, lane_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic [DATA_W-1:0] merged;
   logic [31:0]       c_off;
   logic              c_in_win;
   logic              grant_cpu;
   logic              en_raw, we_raw;

   assign c_off     = c_addr - BASE_ADDR;
   assign c_in_win  = (c_off <= DMEM_WIN_LAST);
   assign grant_cpu = c_req && (!d_req || last_gnt_q == REQ_DBG);

   dmem_lane_merge #(.DATA_W(DATA_W)) u_merge (
      .old_i    (m_rdata),
      .wdata_i  (wdata_q),
      .size_i   (size_q),
      .addr_i   (lane_q),
      .merged_o (merged)
   );

   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      gnt_d      = gnt_q;
      store_d    = store_q;
      size_d     = size_q;
      lane_d     = lane_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      c_rdata_d  = c_rdata_q;
      d_rdata_d  = d_rdata_q;
      en_raw     = 1'b0;
      we_raw     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (grant_cpu) begin
               gnt_d   = REQ_CPU;
               addr_d  = c_off[ADDR_W+1:2];
               lane_d  = c_addr[1:0];
               size_d  = c_size;
               store_d = c_we && (c_size != SZ_NONE);
               wdata_d = c_wdata;
               if (!c_in_win) begin
                  c_rdata_d = '0;
                  state_d   = ST_DONE;
               end else if (c_we && c_size == SZ_W) begin
                  state_d = ST_WR;
               end else begin
                  state_d = ST_RD;
               end
            end else if (d_req) begin
               gnt_d   = REQ_DBG;
               addr_d  = d_addr;
               lane_d  = 2'b00;
               size_d  = SZ_W;
               store_d = d_we;
               wdata_d = d_wdata;
               state_d = d_we ? ST_WR : ST_RD;
            end
         end
         ST_RD: begin
            en_raw  = 1'b1;
            state_d = ST_MERGE;
         end
         // Read data is only valid the cycle after RD, so loads also pass through here.
         ST_MERGE: begin
            if (store_q) begin
               wdata_d = merged;
               state_d = ST_WR;
            end else begin
               if (gnt_q == REQ_CPU) c_rdata_d = m_rdata;
               else                  d_rdata_d = m_rdata;
               state_d = ST_DONE;
            end
         end
         ST_WR: begin
            en_raw  = 1'b1;
            we_raw  = 1'b1;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            last_gnt_d = gnt_q;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESETn) begin
         state_q    <= ST_IDLE;
         last_gnt_q <= REQ_DBG;
         gnt_q      <= REQ_CPU;
         store_q    <= 1'b0;
         size_q     <= SZ_NONE;
         lane_q     <= 2'b00;
         addr_q     <= '0;
         wdata_q    <= '0;
         c_rdata_q  <= '0;
         d_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
         gnt_q      <= gnt_d;
         store_q    <= store_d;
         size_q     <= size_d;
         lane_q     <= lane_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         c_rdata_q  <= c_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

   // Gating with RESETn keeps a reset that lands in WR from committing the write.
   assign m_en    = en_raw && RESETn;
   assign m_we    = we_raw && RESETn;
   assign m_addr  = m_en ? addr_q : '0;
   assign m_wdata = m_we ? wdata_q : '0;
   assign c_ready = (state_q == ST_DONE) && (gnt_q == REQ_CPU);
   assign d_ready = (state_q == ST_DONE) && (gnt_q == REQ_DBG);
   assign c_rdata = c_rdata_q;
   assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - directed self-checking bench for dmem_port_arbiter
module tb_dmem_port_arbiter;

   logic        CLK = 1'b0;
   logic        RESETn = 1'b0;
   logic        c_req = 1'b0, c_we = 1'b0;
   logic [1:0]  c_size = 2'b00;
   logic [31:0] c_addr = '0, c_wdata = '0, c_rdata;
   logic        c_ready;
   logic        d_req = 1'b0, d_we = 1'b0;
   logic [6:0]  d_addr = '0;
   logic [31:0] d_wdata = '0, d_rdata;
   logic        d_ready;
   logic        m_en, m_we;
   logic [6:0]  m_addr;
   logic [31:0] m_wdata, m_rdata;

   logic [31:0] ram [0:127];
   int          en_cnt = 0;
   int          we_cnt = 0;
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 CLK = ~CLK;

   dmem_port_arbiter dut (
      .CLK(CLK), .RESETn(RESETn),
      .c_req(c_req), .c_we(c_we), .c_size(c_size), .c_addr(c_addr),
      .c_wdata(c_wdata), .c_rdata(c_rdata), .c_ready(c_ready),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata)
   );

   always @(posedge CLK) begin
      if (m_en) begin
         en_cnt <= en_cnt + 1;
         if (m_we) begin
            ram[m_addr] <= m_wdata;
            we_cnt      <= we_cnt + 1;
         end else begin
            m_rdata <= ram[m_addr];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cpu_op(input logic we, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd);
      @(negedge CLK);
      c_req = 1'b1; c_we = we; c_size = sz; c_addr = a; c_wdata = wd;
      lat = 99;
      for (int i = 1; i <= 20; i++) begin
         @(posedge CLK);
         @(negedge CLK);
         if (c_ready) begin
            lat = i;
            break;
         end
      end
      rd = c_rdata;
      c_req = 1'b0;
   endtask

   task automatic dbg_op(input logic we, input logic [6:0] a, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd);
      @(negedge CLK);
      d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
      lat = 99;
      for (int i = 1; i <= 20; i++) begin
         @(posedge CLK);
         @(negedge CLK);
         if (d_ready) begin
            lat = i;
            break;
         end
      end
      rd = d_rdata;
      d_req = 1'b0;
   endtask

   task automatic do_reset(input string tag);
      int we_before;
      @(negedge CLK);
      RESETn = 1'b0; c_req = 1'b0; d_req = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check({tag, "_c_rdata"}, c_rdata, 32'h0);
      check({tag, "_d_rdata"}, d_rdata, 32'h0);
      check({tag, "_readies"}, {30'b0, c_ready, d_ready}, 32'h0);
      check({tag, "_m_ctl"}, {30'b0, m_en, m_we}, 32'h0);
      check({tag, "_m_addr"}, {25'b0, m_addr}, 32'h0);
      check({tag, "_m_wdata"}, m_wdata, 32'h0);
      we_before = we_cnt;
      RESETn = 1'b1;
      repeat (2) @(negedge CLK);
      check({tag, "_no_wr_after"}, we_cnt, we_before);
   endtask

   initial begin
      int          lat, n, en_before, we_before, rdy_seen;
      logic [31:0] rd;
      int          order [4];

      do_reset("rst0");

      dbg_op(1'b1, 7'd6, 32'hFEF9_FFF9, lat, rd);  check("dbg_wr6_lat", lat, 2);
      dbg_op(1'b1, 7'd0, 32'h1122_3344, lat, rd);  check("dbg_wr0_lat", lat, 2);

      cpu_op(1'b0, 2'b11, 32'h818, 32'h0, lat, rd);
      check("lw818_lat", lat, 3);  check("lw818_data", rd, 32'hFEF9_FFF9);

      cpu_op(1'b1, 2'b01, 32'h801, 32'h0000_00AB, lat, rd);  check("sb801_lat", lat, 4);
      dbg_op(1'b0, 7'd0, 32'h0, lat, rd);
      check("dbg_rd0_lat", lat, 3);  check("sb801_word", rd, 32'h1122_AB44);

      cpu_op(1'b1, 2'b10, 32'h802, 32'h0000_BEEF, lat, rd);  check("sh802_lat", lat, 4);
      dbg_op(1'b0, 7'd0, 32'h0, lat, rd);  check("sh802_word", rd, 32'hBEEF_AB44);

      cpu_op(1'b1, 2'b11, 32'h804, 32'hDEAD_BEEF, lat, rd);  check("sw804_lat", lat, 2);
      dbg_op(1'b0, 7'd1, 32'h0, lat, rd);  check("sw804_word", rd, 32'hDEAD_BEEF);

      cpu_op(1'b1, 2'b01, 32'h807, 32'hFFFF_FF12, lat, rd);
      cpu_op(1'b0, 2'b11, 32'h804, 32'h0, lat, rd);  check("sb807_word", rd, 32'h12AD_BEEF);
      cpu_op(1'b1, 2'b10, 32'h805, 32'hFFFF_5566, lat, rd);
      cpu_op(1'b0, 2'b11, 32'h804, 32'h0, lat, rd);  check("sh805_word", rd, 32'h12AD_5566);

      cpu_op(1'b1, 2'b00, 32'h818, 32'h1234_5678, lat, rd);
      check("sz00_lat", lat, 3);  check("sz00_data", rd, 32'hFEF9_FFF9);

      en_before = en_cnt;
      cpu_op(1'b1, 2'b11, 32'h400, 32'h0000_0001, lat, rd);  check("oor_sw_lat", lat, 1);
      check("oor_sw_no_men", en_cnt, en_before);
      cpu_op(1'b0, 2'b11, 32'h400, 32'h0, lat, rd);
      check("oor_lw_lat", lat, 1);  check("oor_lw_data", rd, 32'h0);
      cpu_op(1'b0, 2'b11, 32'hA00, 32'h0, lat, rd);  check("oor_top_lat", lat, 1);
      cpu_op(1'b0, 2'b11, 32'h9FC, 32'h0, lat, rd);  check("win_last_lat", lat, 3);

      do_reset("rst1");
      @(negedge CLK);
      c_req = 1'b1; c_we = 1'b0; c_size = 2'b11; c_addr = 32'h818;
      d_req = 1'b1; d_we = 1'b0; d_addr = 7'd0;
      n = 0;
      for (int k = 0; k < 4; k++) order[k] = 2;
      for (int i = 0; i < 60 && n < 4; i++) begin
         @(posedge CLK);
         @(negedge CLK);
         if (c_ready) begin
            order[n] = 0;
            check("arb_c_data", c_rdata, 32'hFEF9_FFF9);
            n++;
         end else if (d_ready) begin
            order[n] = 1;
            check("arb_d_data", d_rdata, 32'hBEEF_AB44);
            n++;
         end
      end
      c_req = 1'b0; d_req = 1'b0;
      for (int k = 0; k < 4; k++) check($sformatf("arb_grant%0d", k), order[k], k % 2);

      @(negedge CLK);
      c_req = 1'b1; c_we = 1'b1; c_size = 2'b01; c_addr = 32'h800; c_wdata = 32'h77;
      repeat (3) begin
         @(posedge CLK);
         @(negedge CLK);
      end
      check("abort_in_wr", {31'b0, m_we}, 32'h1);
      we_before = we_cnt;
      RESETn = 1'b0; c_req = 1'b0;
      rdy_seen = 0;
      @(posedge CLK);
      @(negedge CLK);
      check("abort_m_ctl", {30'b0, m_en, m_we}, 32'h0);
      check("abort_c_rdata", c_rdata, 32'h0);
      RESETn = 1'b1;
      repeat (3) begin
         @(posedge CLK);
         @(negedge CLK);
         if (c_ready || d_ready) rdy_seen++;
      end
      check("abort_no_ready", rdy_seen, 0);
      check("abort_no_write", we_cnt, we_before);
      dbg_op(1'b0, 7'd0, 32'h0, lat, rd);
      check("abort_idle_lat", lat, 3);  check("abort_word0", rd, 32'hBEEF_AB44);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
